// File: rtl/pipe_pkg.sv
// Shared types and defaults for the front-end pipeline sequencer.
package pipe_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam int unsigned RESET_PC_DEF = 0;
    localparam int unsigned CTRL_W_DEF   = 9;
    localparam int unsigned CNT_W        = 32;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        if (en && (v != {CNT_W{1'b1}})) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating stall-cycle and flush counters for the front-end sequencer.
module pipe_perf_cnt
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_evt,
    input  logic             flush_evt,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;

    always_comb begin
        stall_d = sat_inc(stall_q, stall_evt);
        flush_d = sat_inc(flush_q, flush_evt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule

// File: rtl/pipe_front_ctrl.sv
// PC, IF/ID and ID/EX-control sequencing with a variable-latency fetch FSM.
// Performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_front_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INSTR_W  = 32,
    parameter int unsigned       CTRL_W   = CTRL_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_write,
    input  logic               ifid_write,
    input  logic               bubble_req,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic [CTRL_W-1:0]  id_ctrl,
    output logic [ADDR_W-1:0]  pc,
    output logic               imem_req,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc4,
    output logic               ifid_valid,
    output logic [CTRL_W-1:0]  idex_ctrl,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_count
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]  ifid_pc4_q, ifid_pc4_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [CTRL_W-1:0]  idex_ctrl_q, idex_ctrl_d;

    logic [ADDR_W-1:0]  pc_plus4;
    logic               ld_beat;
    logic               ld_nop;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ld_beat      = 1'b0;
        ld_nop       = 1'b0;
        imem_req     = (state_q != DROP);
        idex_ctrl_d  = (bubble_req || !ifid_valid_q) ? '0 : id_ctrl;

        if (branch_taken) begin
            pc_d        = branch_target;
            ld_nop      = 1'b1;
            idex_ctrl_d = '0;
            // A request still outstanding from WAIT/DROP will return a stale beat.
            state_d     = (state_q == FETCH) ? FETCH : DROP;
        end else begin
            unique case (state_q)
                FETCH, WAIT: begin
                    if (imem_valid) begin
                        state_d = FETCH;
                        if (pc_write) begin
                            pc_d    = pc_plus4;
                            ld_beat = ifid_write;
                        end else begin
                            ld_nop  = ifid_write;
                        end
                    end else begin
                        state_d = WAIT;
                        ld_nop  = ifid_write;
                    end
                end
                DROP: begin
                    if (imem_valid) begin
                        state_d = FETCH;
                    end
                    ld_nop = ifid_write;
                end
                default: state_d = FETCH;
            endcase
        end

        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (ld_nop) begin
            ifid_instr_d = INSTR_W'(NOP_INSTR);
            ifid_pc4_d   = '0;
            ifid_valid_d = 1'b0;
        end else if (ld_beat) begin
            ifid_instr_d = imem_rdata;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            ifid_instr_q <= '0;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            idex_ctrl_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            idex_ctrl_q  <= idex_ctrl_d;
        end
    end

    assign pc         = pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;
    assign idex_ctrl  = idex_ctrl_q;

`ifdef PIPE_PERF_CNT_EN
    pipe_perf_cnt u_perf_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_evt    (!pc_write || (state_q == WAIT)),
        .flush_evt    (branch_taken),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: doc/pipe_front_ctrl.md
# pipe_front_ctrl

Front-end pipeline sequencer that acts on the stall and bubble decisions made by hazard detection. It owns the PC register, the IF/ID pipeline register and the control half of the ID/EX register. It holds or advances them per the stall inputs, squashes younger instructions on a taken branch, and tolerates variable-latency instruction memory through a small fetch state machine. It sits between instruction memory, the decoder and the EX-stage branch resolution.

## Interface
Parameters:
- ADDR_W, 32, PC / fetch address width
- INSTR_W, 32, instruction width
- CTRL_W, 9, ID/EX control word width
- RESET_PC, 0, PC value after reset

Ports (clock and reset first):
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- pc_write  in  1  0 = hold PC (load-use stall)
- ifid_write  in  1  0 = hold IF/ID contents
- bubble_req  in  1  1 = load zero control word into ID/EX
- branch_taken  in  1  EX-stage taken branch/jump, one-cycle pulse
- branch_target  in  ADDR_W  redirect address, valid with branch_taken
- imem_rdata  in  INSTR_W  fetched instruction
- imem_valid  in  1  imem_rdata valid this cycle
- id_ctrl  in  CTRL_W  decoder control word for instruction in ID
- pc  out  ADDR_W  fetch address
- imem_req  out  1  fetch request
- ifid_instr  out  INSTR_W  IF/ID instruction
- ifid_pc4  out  ADDR_W  IF/ID PC+4
- ifid_valid  out  1  IF/ID holds a real instruction
- idex_ctrl  out  CTRL_W  ID/EX control word
- stall_cycles  out  32  performance counter
- flush_count  out  32  performance counter

## Operation
- States: FETCH, WAIT, DROP.
- FETCH:
  - imem_req=1.
  - imem_valid=1 and pc_write=1: PC<=PC+4 (mod 2^ADDR_W). If ifid_write=1, IF/ID<={imem_rdata, PC+4, valid=1}.
  - imem_valid=0: go to WAIT, PC held. If ifid_write=1, IF/ID<=NOP (instr 0, valid 0).
- WAIT:
  - imem_req=1, PC held stable.
  - On imem_valid, behave as FETCH-with-valid and return to FETCH.
- DROP:
  - imem_req=0.
  - The next imem_valid beat is discarded, then go to FETCH.
- Stall: pc_write=0 holds PC; ifid_write=0 holds IF/ID. An imem beat that cannot be consumed under pc_write=0 is dropped and refetched; the address is unchanged.
- ID/EX: idex_ctrl<=0 if bubble_req or !ifid_valid; else id_ctrl.
- Taken branch (highest priority, overrides stall inputs):
  - PC<=branch_target.
  - IF/ID<=NOP.
  - idex_ctrl<=0.
  - From FETCH, go to FETCH. From WAIT or DROP, go to DROP so the stale in-flight beat is discarded.
- Simultaneous branch_taken and imem_valid in FETCH: the beat is discarded, and the state goes to FETCH.
- Simultaneous branch_taken and pc_write=0: branch wins.

## Timing
- All outputs are registered except imem_req, which is decoded from state.
- Reset values:
  - pc=RESET_PC
  - ifid_instr=0, ifid_pc4=0, ifid_valid=0
  - idex_ctrl=0
  - counters=0
  - state FETCH (so imem_req=1 after reset)
- Zero-wait memory: one instruction per cycle. IF/ID updates on the edge where imem_valid=1.
- Branch penalty: two squashed slots (IF and ID), visible one edge after the branch_taken pulse.
- Reset asserted mid-WAIT or mid-DROP: all state returns to reset values immediately. Any beat arriving after deassertion is treated as the RESET_PC fetch.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cycles increments each cycle with pc_write=0 or state WAIT.
  - flush_count increments per branch_taken.
  - Both counters saturate at 2^32-1.
- PIPE_PERF_CNT_EN undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Shared package pipe_pkg: fetch-state enum (FETCH/WAIT/DROP), NOP_INSTR constant (0), default RESET_PC, CTRL_W default.
- Sub-module pipe_perf_cnt holds the two saturating counters and is instantiated only under PIPE_PERF_CNT_EN.

## Test plan
- Reset, imem_valid held 1, instructions 0x20080001.. -> pc steps 0,4,8; ifid_pc4=4,8,12; ifid_valid=1 from first edge.
- pc_write=0, ifid_write=0, bubble_req=1 for 1 cycle at pc=8 -> pc stays 8, IF/ID unchanged, idex_ctrl=0 that cycle, then resumes.
- branch_taken with target 0x100 at pc=0x10 -> pc=0x100; ifid_valid=0; idex_ctrl=0 next edge; flush_count=1 (macro on).
- imem_valid low 3 cycles at pc=0x20 -> state WAIT; pc stable 0x20; imem_req=1; ifid_valid=0; stall_cycles=3.
- Branch to 0x40 during WAIT, stale beat 0xDEADBEEF arrives next -> discarded; imem_req=0 until then; next fetch at 0x40.
- pc=0xFFFFFFFC advance -> pc wraps to 0; ifid_pc4=0.
